// File: rtl/rr_arb16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
package rr_arb16_pkg;

    localparam int NREQ             = 16;
    localparam int ID_W             = 4;
    localparam int HOLD_W           = 4;
    localparam int MAX_HOLD_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb16_dec4x16.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module dec4x16
    import rr_arb16_pkg::*;
(
    input  logic [ID_W-1:0] i_sel,
    input  logic            i_en,
    output logic [NREQ-1:0] o_dec
);

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dec
            assign o_dec[gi] = i_en && (i_sel == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arb16.sv
// 16-requester round-robin arbiter with a bounded hold time per grant.
// A holder keeps the grant until it drops its request, or until it has
// held for MAX_HOLD cycles while someone else is waiting.
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ID_W-1:0]   r_gnt_id;
    logic [ID_W-1:0]   w_gnt_id_next;
    logic              r_gnt_valid;
    logic              w_gnt_valid_next;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_next;
    logic [ID_W-1:0]   r_last;
    logic [ID_W-1:0]   w_last_next;

    logic [NREQ-1:0]   w_gnt;
    logic [NREQ-1:0]   w_cand;
    logic [ID_W-1:0]   w_start;
    logic [ID_W-1:0]   w_pick_id;
    logic              w_pick_found;
    logic              w_holder_req;
    logic              w_hold_limit;

    dec4x16 u_dec (
        .i_sel (r_gnt_id),
        .i_en  (r_gnt_valid),
        .o_dec (w_gnt)
    );

    assign gnt       = w_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

    // The decoded grant masks the holder out of the candidate set; in IDLE
    // it is zero, so every requester competes.
    assign w_cand       = req & ~w_gnt;
    assign w_start      = r_last + 1'b1;
    assign w_holder_req = |(req & w_gnt);
    assign w_hold_limit = (r_hold == HOLD_LAST);

    // Round-robin search: first candidate at or after last+1, wrapping 15->0.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_pick_found && w_cand[w_start + ID_W'(i)]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_start + ID_W'(i);
            end
        end
    end

    // Next-state logic: issue, hold, hand over or release the grant.
    always_comb begin
        w_state_next     = r_state;
        w_gnt_id_next    = r_gnt_id;
        w_gnt_valid_next = r_gnt_valid;
        w_hold_next      = r_hold;
        w_last_next      = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_next     = ST_GRANT;
                    w_gnt_id_next    = w_pick_id;
                    w_gnt_valid_next = 1'b1;
                    w_hold_next      = '0;
                    w_last_next      = w_pick_id;
                end
            end
            ST_GRANT: begin
                if (!w_holder_req || (w_hold_limit && w_pick_found)) begin
                    if (w_pick_found) begin
                        // Hand over on the same edge, no idle cycle.
                        w_gnt_id_next = w_pick_id;
                        w_hold_next   = '0;
                        w_last_next   = w_pick_id;
                    end else begin
                        w_state_next     = ST_IDLE;
                        w_gnt_valid_next = 1'b0;
                        w_hold_next      = '0;
                    end
                end else if (!w_hold_limit) begin
                    // Saturates at MAX_HOLD-1 when nobody competes.
                    w_hold_next = r_hold + 1'b1;
                end
            end
        endcase
    end

    // State registers; reset leaves last=15 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_hold      <= '0;
            r_last      <= '1;
        end else begin
            r_state     <= w_state_next;
            r_gnt_id    <= w_gnt_id_next;
            r_gnt_valid <= w_gnt_valid_next;
            r_hold      <= w_hold_next;
            r_last      <= w_last_next;
        end
    end

endmodule
